jtkcpu_intgen: RTL and testbench

Interrupt request generator driving the JTKCPU interrupt inputs `nmi_n`, `firq_n` and `irq_n`. It converts peripheral event pulses into CPU interrupt lines, holds them until the CPU acknowledges, and releases them when the CPU reads the matching vector. It sits between the game's peripheral logic and the CPU core, and observes the CPU bus to detect vector fetches. It is clocked on the same `clk`/`cen` as the CPU.

---
 rtl/jtkcpu_intgen.sv | 175 +++++++++++++++++
 tb/tb_jtkcpu_intgen.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtkcpu_intgen.sv
// jtkcpu_intgen: turns peripheral event pulses into JTKCPU interrupt lines.
// FIRQ/IRQ are level lines held until the CPU fetches their vector, software
// clears them, the optional timeout expires, or their enable drops.
// NMI is a fixed-width pulse with a guaranteed high gap and one stored event.
module jtkcpu_intgen #(
  parameter int unsigned NMI_LEN = 8,
  parameter int unsigned NMI_GAP = 2,
  parameter int unsigned IRQ_TMO = 0
)(
  input  logic        rst,
  input  logic        clk,
  input  logic        cen,
  input  logic        nmi_req,
  input  logic        firq_req,
  input  logic        irq_req,
  input  logic        firq_en,
  input  logic        irq_en,
  input  logic        firq_clr,
  input  logic        irq_clr,
  input  logic [15:0] addr,
  input  logic        rd,
  output logic        nmi_n,
  output logic        firq_n,
  output logic        irq_n,
  output logic [1:0]  missed
);

  localparam logic [7:0]  LEN_LOAD = 8'(NMI_LEN - 1);
  localparam logic [7:0]  GAP_LOAD = 8'(NMI_GAP - 1);
  localparam logic [15:0] TMO_LAST = 16'(IRQ_TMO - 1);
  localparam bit          TMO_ON   = (IRQ_TMO != 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOW,
    ST_GAP
  } nmi_state_t;

  logic nmi_last, firq_last, irq_last;
  logic nmi_edge, firq_edge, irq_edge;
  logic ack_nmi, ack_firq, ack_irq;

  // Only the upper address bits pick the vector, so bit 0 is deliberately unused.
  logic unused_addr;
  assign unused_addr = addr[0];

  // Channel vectors: index 1 is FIRQ, index 0 is IRQ (same order as missed).
  logic [1:0]       ch_edge, ch_en, ch_ack, ch_clr;
  logic [1:0]       pend, pend_nx, timeout;
  logic [1:0][15:0] tmo, tmo_nx;

  nmi_state_t st, st_nx;
  logic [7:0] cnt, cnt_nx;
  logic       nmi_pend, nmi_pend_nx;

  // Previous request samples; an event is "sampled high now, low before".
  always_ff @(posedge clk) begin
    if (rst) begin
      nmi_last  <= 1'b0;
      firq_last <= 1'b0;
      irq_last  <= 1'b0;
    end else if (cen) begin
      nmi_last  <= nmi_req;
      firq_last <= firq_req;
      irq_last  <= irq_req;
    end
  end

  assign nmi_edge  = nmi_req  & ~nmi_last;
  assign firq_edge = firq_req & ~firq_last;
  assign irq_edge  = irq_req  & ~irq_last;

  // Vector fetches: FFF6/7 FIRQ, FFF8/9 IRQ, FFFC/D NMI.
  assign ack_firq = rd & cen & (addr[15:1] == 15'h7FFB);
  assign ack_irq  = rd & cen & (addr[15:1] == 15'h7FFC);
  assign ack_nmi  = rd & cen & (addr[15:1] == 15'h7FFE);

  assign ch_edge = {firq_edge, irq_edge};
  assign ch_en   = {firq_en,   irq_en};
  assign ch_ack  = {ack_firq,  ack_irq};
  assign ch_clr  = {firq_clr,  irq_clr};

  // Level channels: enable low wins, then a new event, then any clear source.
  always_comb begin
    pend_nx = pend;
    tmo_nx  = tmo;
    timeout = 2'b00;
    for (int i = 0; i < 2; i++) begin
      if (!ch_en[i]) begin
        pend_nx[i] = 1'b0;
        tmo_nx[i]  = 16'd0;
      end else if (ch_edge[i]) begin
        pend_nx[i] = 1'b1;
        tmo_nx[i]  = 16'd0;
      end else if (pend[i] && (ch_ack[i] || ch_clr[i])) begin
        pend_nx[i] = 1'b0;
        tmo_nx[i]  = 16'd0;
      end else if (TMO_ON && pend[i] && (tmo[i] == TMO_LAST)) begin
        pend_nx[i] = 1'b0;
        tmo_nx[i]  = 16'd0;
        timeout[i] = 1'b1;
      end else if (TMO_ON && pend[i]) begin
        tmo_nx[i]  = tmo[i] + 16'd1;
      end
    end
  end

  // Level channel registers; the lines are registered copies of ~pend.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend   <= 2'b00;
      tmo    <= '0;
      missed <= 2'b00;
      firq_n <= 1'b1;
      irq_n  <= 1'b1;
    end else if (cen) begin
      pend   <= pend_nx;
      tmo    <= tmo_nx;
      missed <= timeout;
      firq_n <= ~pend_nx[1];
      irq_n  <= ~pend_nx[0];
    end
  end

  // NMI pulse sequencing: low for NMI_LEN (or until acked), then a high gap.
  always_comb begin
    st_nx       = st;
    cnt_nx      = cnt;
    nmi_pend_nx = nmi_pend;
    case (st)
      ST_IDLE: begin
        if (nmi_edge || nmi_pend) begin
          st_nx       = ST_LOW;
          cnt_nx      = LEN_LOAD;
          nmi_pend_nx = 1'b0;
        end
      end
      ST_LOW: begin
        if (nmi_edge) nmi_pend_nx = 1'b1;
        if ((cnt == 8'd0) || ack_nmi) begin
          st_nx  = ST_GAP;
          cnt_nx = GAP_LOAD;
        end else begin
          cnt_nx = cnt - 8'd1;
        end
      end
      ST_GAP: begin
        if (nmi_edge) nmi_pend_nx = 1'b1;
        if (cnt == 8'd0) st_nx = ST_IDLE;
        else             cnt_nx = cnt - 8'd1;
      end
      default: begin
        st_nx       = ST_IDLE;
        cnt_nx      = 8'd0;
        nmi_pend_nx = 1'b0;
      end
    endcase
  end

  // NMI state register; nmi_n follows the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= ST_IDLE;
      cnt      <= 8'd0;
      nmi_pend <= 1'b0;
      nmi_n    <= 1'b1;
    end else if (cen) begin
      st       <= st_nx;
      cnt      <= cnt_nx;
      nmi_pend <= nmi_pend_nx;
      nmi_n    <= (st_nx != ST_LOW);
    end
  end

endmodule

// File: tb/tb_jtkcpu_intgen.sv
// tb_jtkcpu_intgen: directed scenarios plus random traffic, checked every
// cycle against a timeline model (NMI low window and earliest restart cycle,
// FIRQ/IRQ pending flag and the cen cycle it was raised).
module tb_jtkcpu_intgen;

  localparam int NMI_LEN = 8;
  localparam int NMI_GAP = 2;
  localparam int IRQ_TMO = 16;

  logic        rst, clk, cen;
  logic        nmi_req, firq_req, irq_req;
  logic        firq_en, irq_en, firq_clr, irq_clr;
  logic [15:0] addr;
  logic        rd;
  logic        nmi_n, firq_n, irq_n;
  logic [1:0]  missed;

  int tests_run;
  int tests_failed;

  // Reference model state
  int       kc;
  int       low_from, low_to, free_at;
  bit       m_nmi_pend, m_nmi_prev;
  bit [1:0] m_prev, m_pend, m_missed;
  int       set_at [2];

  jtkcpu_intgen #(
    .NMI_LEN (NMI_LEN),
    .NMI_GAP (NMI_GAP),
    .IRQ_TMO (IRQ_TMO)
  ) dut (
    .rst      (rst),
    .clk      (clk),
    .cen      (cen),
    .nmi_req  (nmi_req),
    .firq_req (firq_req),
    .irq_req  (irq_req),
    .firq_en  (firq_en),
    .irq_en   (irq_en),
    .firq_clr (firq_clr),
    .irq_clr  (irq_clr),
    .addr     (addr),
    .rd       (rd),
    .nmi_n    (nmi_n),
    .firq_n   (firq_n),
    .irq_n    (irq_n),
    .missed   (missed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    low_from   = 1;
    low_to     = 0;
    free_at    = 0;
    m_nmi_pend = 1'b0;
    m_nmi_prev = 1'b0;
    m_prev     = 2'b00;
    m_pend     = 2'b00;
    m_missed   = 2'b00;
    set_at     = '{0, 0};
  endtask

  // Advance the model by one clk edge using the inputs the DUT just sampled.
  task automatic model_step();
    bit       e_nmi, ack_nmi;
    bit [1:0] e, en, ack, clr;
    int       k;
    if (rst) begin
      model_reset();
      return;
    end
    if (!cen) return;
    k = kc;
    e_nmi      = nmi_req && !m_nmi_prev;
    m_nmi_prev = nmi_req;
    e          = {firq_req && !m_prev[1], irq_req && !m_prev[0]};
    m_prev     = {firq_req, irq_req};
    en         = {firq_en, irq_en};
    clr        = {firq_clr, irq_clr};
    ack[1]     = rd && (addr == 16'hFFF6 || addr == 16'hFFF7);
    ack[0]     = rd && (addr == 16'hFFF8 || addr == 16'hFFF9);
    ack_nmi    = rd && (addr == 16'hFFFC || addr == 16'hFFFD);

    if (k >= free_at) begin
      if (e_nmi || m_nmi_pend) begin
        low_from   = k + 1;
        low_to     = k + NMI_LEN;
        free_at    = low_to + NMI_GAP + 1;
        m_nmi_pend = 1'b0;
      end
    end else begin
      if (ack_nmi && k >= low_from && k <= low_to) begin
        low_to  = k;
        free_at = k + NMI_GAP + 1;
      end
      if (e_nmi) m_nmi_pend = 1'b1;
    end

    for (int i = 0; i < 2; i++) begin
      m_missed[i] = 1'b0;
      if (!en[i]) begin
        m_pend[i] = 1'b0;
      end else if (e[i]) begin
        m_pend[i] = 1'b1;
        set_at[i] = k;
      end else if (m_pend[i] && (ack[i] || clr[i])) begin
        m_pend[i] = 1'b0;
      end else if (m_pend[i] && IRQ_TMO != 0 && (k - set_at[i]) == IRQ_TMO) begin
        m_pend[i]   = 1'b0;
        m_missed[i] = 1'b1;
      end
    end
    kc++;
  endtask

  // One clock: model update at the edge, DUT outputs compared 1 ns later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    checkOutput("nmi_n",  16'(nmi_n),  16'(!(kc >= low_from && kc <= low_to)));
    checkOutput("firq_n", 16'(firq_n), 16'(!m_pend[1]));
    checkOutput("irq_n",  16'(irq_n),  16'(!m_pend[0]));
    checkOutput("missed", 16'(missed), 16'(m_missed));
  endtask

  task automatic set_idle();
    rst      = 1'b0;
    cen      = 1'b1;
    nmi_req  = 1'b0;
    firq_req = 1'b0;
    irq_req  = 1'b0;
    firq_en  = 1'b1;
    irq_en   = 1'b1;
    firq_clr = 1'b0;
    irq_clr  = 1'b0;
    rd       = 1'b0;
    addr     = 16'h0000;
  endtask

  task automatic applyStimulus();
    cen      = ($urandom_range(0, 3) != 0);
    rst      = ($urandom_range(0, 599) == 0);
    if ($urandom_range(0, 19) == 0) nmi_req  = ~nmi_req;
    if ($urandom_range(0, 9) == 0)  firq_req = ~firq_req;
    if ($urandom_range(0, 9) == 0)  irq_req  = ~irq_req;
    firq_en  = ($urandom_range(0, 49) != 0);
    irq_en   = ($urandom_range(0, 49) != 0);
    firq_clr = ($urandom_range(0, 39) == 0);
    irq_clr  = ($urandom_range(0, 39) == 0);
    rd       = ($urandom_range(0, 3) == 0);
    case ($urandom_range(0, 7))
      0:       addr = 16'hFFF6;
      1:       addr = 16'hFFF7;
      2:       addr = 16'hFFF8;
      3:       addr = 16'hFFF9;
      4:       addr = 16'hFFFC;
      5:       addr = 16'hFFFD;
      6:       addr = 16'hFFFA;
      default: addr = 16'($urandom);
    endcase
  endtask

  initial begin
    logic [47:0] hist;
    int low_a, low_b, low_c, gap_hi;
    int f_low, m_cnt, i_low;

    tests_run    = 0;
    tests_failed = 0;
    kc           = 0;
    model_reset();
    set_idle();

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    checkOutput("reset_nmi_n",  16'(nmi_n),  16'd1);
    checkOutput("reset_firq_n", 16'(firq_n), 16'd1);
    checkOutput("reset_irq_n",  16'(irq_n),  16'd1);
    checkOutput("reset_missed", 16'(missed), 16'd0);
    rst = 1'b0;
    repeat (3) tick();

    // IRQ set and vector acknowledge
    irq_req = 1'b1;
    tick();
    checkOutput("irq_set_low", 16'(irq_n), 16'd0);
    irq_req = 1'b0;
    repeat (8) tick();
    checkOutput("irq_held", 16'(irq_n), 16'd0);
    rd   = 1'b1;
    addr = 16'hFFF8;
    tick();
    checkOutput("irq_ack_high", 16'(irq_n), 16'd1);
    addr = 16'hFFF9;
    tick();
    rd   = 1'b0;
    addr = 16'h0000;
    repeat (4) tick();

    // NMI pulse shape, one stored event, third edge merged
    hist    = '0;
    nmi_req = 1'b1;
    tick();
    hist[0] = nmi_n;
    for (int i = 1; i < 48; i++) begin
      nmi_req = (i == 2 || i == 4);
      tick();
      hist[i] = nmi_n;
    end
    low_a = 0; low_b = 0; low_c = 0; gap_hi = 0;
    for (int i = 0; i < 8; i++)   if (!hist[i]) low_a++;
    for (int i = 8; i < 11; i++)  if (hist[i])  gap_hi++;
    for (int i = 11; i < 19; i++) if (!hist[i]) low_b++;
    for (int i = 19; i < 48; i++) if (!hist[i]) low_c++;
    checkOutput("nmi_first_low",  16'(low_a),  16'd8);
    checkOutput("nmi_gap_high",   16'(gap_hi), 16'd3);
    checkOutput("nmi_second_low", 16'(low_b),  16'd8);
    checkOutput("nmi_merged",     16'(low_c),  16'd0);

    // NMI early acknowledge, then a new edge during the gap
    nmi_req = 1'b1;
    tick();
    checkOutput("nmi_early_low", 16'(nmi_n), 16'd0);
    nmi_req = 1'b0;
    tick();
    tick();
    rd   = 1'b1;
    addr = 16'hFFFC;
    tick();
    checkOutput("nmi_ack_release", 16'(nmi_n), 16'd1);
    rd      = 1'b0;
    addr    = 16'h0000;
    nmi_req = 1'b1;
    tick();
    nmi_req = 1'b0;
    tick();
    checkOutput("nmi_relaunch_wait", 16'(nmi_n), 16'd1);
    tick();
    checkOutput("nmi_relaunch_low", 16'(nmi_n), 16'd0);
    repeat (14) tick();

    // FIRQ timeout
    firq_req = 1'b1;
    tick();
    f_low = (firq_n == 1'b0) ? 1 : 0;
    m_cnt = 0;
    i_low = (irq_n == 1'b0) ? 1 : 0;
    firq_req = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (firq_n == 1'b0)    f_low++;
      if (missed == 2'b10)   m_cnt++;
      if (irq_n == 1'b0)     i_low++;
    end
    checkOutput("firq_tmo_len",   16'(f_low), 16'd16);
    checkOutput("firq_missed",    16'(m_cnt), 16'd1);
    checkOutput("irq_unaffected", 16'(i_low), 16'd0);

    // Set/clear collisions and enables
    irq_req = 1'b1;
    irq_clr = 1'b1;
    tick();
    checkOutput("irq_set_beats_clr", 16'(irq_n), 16'd0);
    irq_req = 1'b0;
    irq_clr = 1'b0;
    tick();
    irq_clr = 1'b1;
    tick();
    checkOutput("irq_sw_clr", 16'(irq_n), 16'd1);
    irq_clr = 1'b0;
    irq_en  = 1'b0;
    irq_req = 1'b1;
    tick();
    checkOutput("irq_en_blocks", 16'(irq_n), 16'd1);
    irq_req  = 1'b0;
    irq_en   = 1'b1;
    firq_req = 1'b1;
    tick();
    checkOutput("firq_set", 16'(firq_n), 16'd0);
    firq_req = 1'b0;
    firq_en  = 1'b0;
    tick();
    checkOutput("firq_en_drop", 16'(firq_n), 16'd1);
    firq_en = 1'b1;

    // cen low freezes everything, including vector reads
    irq_req = 1'b1;
    tick();
    irq_req = 1'b0;
    cen     = 1'b0;
    rd      = 1'b1;
    addr    = 16'hFFF8;
    repeat (3) tick();
    checkOutput("cen_low_hold", 16'(irq_n), 16'd0);
    cen = 1'b1;
    tick();
    checkOutput("cen_high_ack", 16'(irq_n), 16'd1);
    rd   = 1'b0;
    addr = 16'h0000;
    repeat (12) tick();

    // Reset mid-operation
    nmi_req  = 1'b1;
    firq_req = 1'b1;
    irq_req  = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    checkOutput("rst_nmi_n",  16'(nmi_n),  16'd1);
    checkOutput("rst_firq_n", 16'(firq_n), 16'd1);
    checkOutput("rst_irq_n",  16'(irq_n),  16'd1);
    nmi_req  = 1'b0;
    firq_req = 1'b0;
    irq_req  = 1'b0;
    tick();
    rst   = 1'b0;
    low_a = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (nmi_n == 1'b0) low_a++;
    end
    checkOutput("no_residual_nmi", 16'(low_a), 16'd0);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      applyStimulus();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
